game_sequencer: RTL and testbench
=================================

# game_sequencer

Turn-level controller for the code-breaking game. It latches the secret code, accepts guesses and drives the guess-history store (its `mode` and store-strobe inputs). It scores each guess sequentially into black/white peg counts and tracks the turn count up to the 8-turn limit. It sits between the debounced button logic and the history/display datapath.

## Interface
- No parameters; fixed at 4 pegs × 3-bit colours, 8 turns.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `new_game`  in  1  one-cycle pulse; latch `secret_in` and start turn 0.
- `btn_select`  in  1  one-cycle debounced pulse; submit current guess.
- `btn_mode`  in  1  one-cycle debounced pulse; toggle entry/history view.
- `secret_in`  in  12  code {peg3,peg2,peg1,peg0}, 3 bits each, peg3 in [11:9].
- `guess_in`  in  12  current guess, same packing.
- `mode`  out  1  0 = entry, 1 = history view; drives history `mode`.
- `store`  out  1  one-cycle pulse; drives history store strobe.
- `turn`  out  3  current turn index 0..7.
- `black`  out  3  exact-position matches 0..4.
- `white`  out  3  colour-only matches 0..4.
- `score_valid`  out  1  one-cycle pulse when `black`/`white` update.
- `busy`  out  1  high in SCORE_B/SCORE_W.
- `win`, `lose`  out  1 each  high, and held, in WIN / LOSE.

## Operation
- States: IDLE, ENTRY, SCORE_B, SCORE_W, RESULT, WIN, LOSE.
- Reset: state IDLE; every output 0; internal secret/guess latches 0.
- IDLE: ignores everything except `new_game`.
- `new_game` in any state:
  - latch `secret_in`; clear `turn`, `black`, `white`, `mode`, `win`, `lose`;
  - go to ENTRY; abort any scoring in progress, with no `score_valid` and no `store`.
- ENTRY, `mode`=0, `btn_select`:
  - latch `guess_in`; go to SCORE_B;
  - assert `store` the following cycle;
  - clear internal match masks `gm[3:0]`, `sm[3:0]` and the black/white accumulators.
- ENTRY, `mode`=1: `btn_select` ignored.
- `btn_mode` toggles `mode` in ENTRY, WIN and LOSE. It is ignored in IDLE, SCORE_B, SCORE_W and RESULT, where `mode` is held at 0.
- SCORE_B: 4 cycles, peg k = 0..3, one per cycle.
  - If g[k]==s[k]: increment black accumulator; set gm[k], sm[k].
- SCORE_W: 16 cycles, i outer 0..3 over guess pegs, j inner 0..3 over secret pegs, one (i,j) per cycle.
  - If !gm[i] && !sm[j] && g[i]==s[j]: increment white accumulator; set gm[i], sm[j].
  - This gives standard Mastermind counts; each peg matches at most once.
- RESULT: 1 cycle. Copy accumulators to `black`/`white` and pulse `score_valid`. Next state:
  - WIN if black==4;
  - else LOSE if `turn`==7;
  - else increment `turn` and return to ENTRY.
- WIN/LOSE: terminal until `new_game` or `rst`. `btn_select` is ignored; history browsing via `btn_mode` is allowed.
- Accumulators are 3 bits and cannot exceed 4. `turn` never wraps: at 7 it goes to LOSE instead of incrementing.

## Timing
- Cycle 0 = `btn_select` sampled high in ENTRY.
- Cycle 1: `store`=1 for exactly one cycle; `busy`=1 from cycle 1 through 20.
- Cycles 1–4 SCORE_B; cycles 5–20 SCORE_W; cycle 21 RESULT with `score_valid`=1 and new `black`/`white` visible.
- Cycle 22: state is ENTRY/WIN/LOSE. `turn` has its new value and `win`/`lose` are asserted from cycle 22.
- `black`/`white` hold their values until the next RESULT or `new_game`.
- Simultaneous pulses:
  - `new_game` + `btn_select`: `new_game` wins; the guess is dropped.
  - `btn_select` + `btn_mode` in ENTRY with `mode`=0: the guess is accepted; `mode` is unchanged.
- `rst` asserted at any time returns to reset values on the next edge, overriding `new_game`.

## Test plan
- Reset → all outputs 0, state IDLE; `btn_select` in IDLE → no `store`, `turn` stays 0.
- `new_game` with secret {1,2,3,4} (12'o1234), guess {1,2,4,3} → `store` at cycle 1; at cycle 21 `score_valid`=1, black=2, white=2; `turn`=1 at cycle 22.
- Secret {1,2,3,4}, guess {1,1,2,2} → black=1, white=1 (duplicate colours counted once); guess {4,3,2,1} → black=0, white=4.
- Guess equal to the secret on turn 3 → black=4, `win`=1 from cycle 22; further `btn_select` gives no `store`; `btn_mode` toggles `mode`.
- Eight wrong guesses → `lose`=1 after the 8th RESULT; `turn` stays 7 and never wraps to 0.
- `new_game` pulsed at cycle 10 of scoring → no `score_valid`, `turn`=0, state ENTRY. `btn_mode` during SCORE_W → `mode` remains 0.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Button/code inputs and score/status outputs of the turn-level game controller.
interface game_sequencer_if;
    logic        new_game;
    logic        btn_select;
    logic        btn_mode;
    logic [11:0] secret_in;
    logic [11:0] guess_in;
    logic        mode;
    logic        store;
    logic [2:0]  turn;
    logic [2:0]  black;
    logic [2:0]  white;
    logic        score_valid;
    logic        busy;
    logic        win;
    logic        lose;

    // Button logic / stimulus side
    modport master (
        output new_game, btn_select, btn_mode, secret_in, guess_in,
        input  mode, store, turn, black, white, score_valid, busy, win, lose
    );

    // Sequencer side
    modport slave (
        input  new_game, btn_select, btn_mode, secret_in, guess_in,
        output mode, store, turn, black, white, score_valid, busy, win, lose
    );
endinterface

// File: rtl/game_sequencer.sv
// Turn-level controller for the code-breaking game: latches the secret,
// accepts guesses, scores them one comparison per cycle and tracks turns.
module game_sequencer (
    input  logic              clk,
    input  logic              rst,
    game_sequencer_if.slave   bus
);

    localparam int unsigned CODE_W = 12;
    localparam int unsigned PEG_W  = 3;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [2:0] {
        IDLE, ENTRY, SCORE_B, SCORE_W, RESULT, WIN, LOSE
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   secret_q, secret_d;
    logic [CODE_W-1:0]   guess_q, guess_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [3:0]          gm_q, gm_d;
    logic [3:0]          sm_q, sm_d;
    logic [CNT_W-1:0]    acc_b_q, acc_b_d;
    logic [CNT_W-1:0]    acc_w_q, acc_w_d;
    logic                mode_q, mode_d;
    logic                store_q, store_d;
    logic [2:0]          turn_q, turn_d;
    logic [CNT_W-1:0]    black_q, black_d;
    logic [CNT_W-1:0]    white_q, white_d;
    logic                score_valid_q, score_valid_d;
    logic                busy_q, busy_d;
    logic                win_q, win_d;
    logic                lose_q, lose_d;

    // Extract peg k (peg0 in the low bits) from a packed code
    function automatic logic [PEG_W-1:0] peg_at(input logic [CODE_W-1:0] code,
                                                input logic [1:0] k);
        logic [PEG_W-1:0] p;
        case (k)
            2'd0:    p = code[2:0];
            2'd1:    p = code[5:3];
            2'd2:    p = code[8:6];
            default: p = code[11:9];
        endcase
        return p;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            secret_q      <= '0;
            guess_q       <= '0;
            idx_q         <= '0;
            gm_q          <= '0;
            sm_q          <= '0;
            acc_b_q       <= '0;
            acc_w_q       <= '0;
            mode_q        <= 1'b0;
            store_q       <= 1'b0;
            turn_q        <= '0;
            black_q       <= '0;
            white_q       <= '0;
            score_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            secret_q      <= secret_d;
            guess_q       <= guess_d;
            idx_q         <= idx_d;
            gm_q          <= gm_d;
            sm_q          <= sm_d;
            acc_b_q       <= acc_b_d;
            acc_w_q       <= acc_w_d;
            mode_q        <= mode_d;
            store_q       <= store_d;
            turn_q        <= turn_d;
            black_q       <= black_d;
            white_q       <= white_d;
            score_valid_q <= score_valid_d;
            busy_q        <= busy_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    // Next-state, scoring datapath and registered-output next values
    always_comb begin
        state_d       = state_q;
        secret_d      = secret_q;
        guess_d       = guess_q;
        idx_d         = idx_q;
        gm_d          = gm_q;
        sm_d          = sm_q;
        acc_b_d       = acc_b_q;
        acc_w_d       = acc_w_q;
        mode_d        = mode_q;
        store_d       = 1'b0;
        turn_d        = turn_q;
        black_d       = black_q;
        white_d       = white_q;
        score_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
            end
            ENTRY: begin
                if (!mode_q && bus.btn_select) begin
                    // A simultaneous btn_mode is dropped: mode stays at entry view
                    guess_d = bus.guess_in;
                    state_d = SCORE_B;
                    store_d = 1'b1;
                    idx_d   = '0;
                    gm_d    = '0;
                    sm_d    = '0;
                    acc_b_d = '0;
                    acc_w_d = '0;
                end else if (bus.btn_mode) begin
                    mode_d = !mode_q;
                end
            end
            SCORE_B: begin
                if (peg_at(guess_q, idx_q[1:0]) == peg_at(secret_q, idx_q[1:0])) begin
                    acc_b_d          = acc_b_q + CNT_W'(1);
                    gm_d[idx_q[1:0]] = 1'b1;
                    sm_d[idx_q[1:0]] = 1'b1;
                end
                if (idx_q[1:0] == 2'd3) begin
                    idx_d   = '0;
                    state_d = SCORE_W;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            SCORE_W: begin
                // idx[3:2] walks guess pegs (outer), idx[1:0] secret pegs (inner)
                if (!gm_q[idx_q[3:2]] && !sm_q[idx_q[1:0]] &&
                    (peg_at(guess_q, idx_q[3:2]) == peg_at(secret_q, idx_q[1:0]))) begin
                    acc_w_d          = acc_w_q + CNT_W'(1);
                    gm_d[idx_q[3:2]] = 1'b1;
                    sm_d[idx_q[1:0]] = 1'b1;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(15)) begin
                    state_d       = RESULT;
                    black_d       = acc_b_q;
                    white_d       = acc_w_d;
                    score_valid_d = 1'b1;
                end
            end
            RESULT: begin
                if (black_q == CNT_W'(4)) begin
                    state_d = WIN;
                end else if (turn_q == 3'd7) begin
                    state_d = LOSE;
                end else begin
                    turn_d  = turn_q + 3'd1;
                    state_d = ENTRY;
                end
            end
            WIN, LOSE: begin
                if (bus.btn_mode) begin
                    mode_d = !mode_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New game overrides everything, aborting any scoring in progress
        if (bus.new_game) begin
            secret_d      = bus.secret_in;
            state_d       = ENTRY;
            turn_d        = '0;
            black_d       = '0;
            white_d       = '0;
            mode_d        = 1'b0;
            store_d       = 1'b0;
            score_valid_d = 1'b0;
            idx_d         = '0;
            gm_d          = '0;
            sm_d          = '0;
            acc_b_d       = '0;
            acc_w_d       = '0;
        end

        busy_d = (state_d == SCORE_B) || (state_d == SCORE_W);
        win_d  = (state_d == WIN);
        lose_d = (state_d == LOSE);
    end

    assign bus.mode        = mode_q;
    assign bus.store       = store_q;
    assign bus.turn        = turn_q;
    assign bus.black       = black_q;
    assign bus.white       = white_q;
    assign bus.score_valid = score_valid_q;
    assign bus.busy        = busy_q;
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a scoreboard of expected results.
module tb_game_sequencer;

    logic clk;
    logic rst;
    game_sequencer_if bus ();

    game_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0] b;
        logic [2:0] w;
        logic [2:0] t;
        logic       win;
        logic       lose;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [11:0] secret_m = '0;
    logic [2:0]  turn_m   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Mastermind reference: black by position, total by colour histogram
    task automatic score_model(input logic [11:0] s, input logic [11:0] g,
                               output logic [2:0] b, output logic [2:0] w);
        int cg[8];
        int cs[8];
        int nb;
        int tot;
        logic [11:0] sv;
        logic [11:0] gv;
        nb = 0;
        tot = 0;
        sv = s;
        gv = g;
        for (int c = 0; c < 8; c++) begin
            cg[c] = 0;
            cs[c] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            if (sv[3*k +: 3] == gv[3*k +: 3]) nb++;
            cg[gv[3*k +: 3]]++;
            cs[sv[3*k +: 3]]++;
        end
        for (int c = 0; c < 8; c++) tot += (cg[c] < cs[c]) ? cg[c] : cs[c];
        b = 3'(nb);
        w = 3'(tot - nb);
    endtask

    task automatic start_game(input logic [11:0] s);
        bus.secret_in = s;
        bus.new_game  = 1'b1;
        tick();
        bus.new_game  = 1'b0;
        secret_m      = s;
        turn_m        = '0;
    endtask

    // Submit one guess, check the full 22-cycle timeline against the scoreboard
    task automatic play_guess(input logic [11:0] g, input bit with_mode);
        exp_t e;
        exp_t got;
        int   n;
        int   busy_cnt;
        logic [2:0] b;
        logic [2:0] w;
        score_model(secret_m, g, b, w);
        e.b = b;
        e.w = w;
        e.win = 1'b0;
        e.lose = 1'b0;
        if (b == 3'd4) begin
            e.win = 1'b1;
        end else if (turn_m == 3'd7) begin
            e.lose = 1'b1;
        end else begin
            turn_m = turn_m + 3'd1;
        end
        e.t = turn_m;
        sb.push_back(e);

        bus.guess_in   = g;
        bus.btn_select = 1'b1;
        bus.btn_mode   = with_mode ? 1'b1 : 1'b0;
        tick();
        bus.btn_select = 1'b0;
        bus.btn_mode   = 1'b0;
        check("store_cycle1", 32'(bus.store), 1);
        check("mode_cycle1", 32'(bus.mode), 0);
        busy_cnt = 32'(bus.busy);
        n = 1;
        while (bus.score_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 2) check("store_one_cycle", 32'(bus.store), 0);
            busy_cnt += 32'(bus.busy);
        end
        check("score_latency", 32'(n), 21);
        check("busy_cycles", 32'(busy_cnt), 20);
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 32'(sb.size()), 1);
        end else begin
            got = sb.pop_front();
            check("black", 32'(bus.black), 32'(got.b));
            check("white", 32'(bus.white), 32'(got.w));
            tick();
            check("score_valid_pulse", 32'(bus.score_valid), 0);
            check("turn_after", 32'(bus.turn), 32'(got.t));
            check("win_after", 32'(bus.win), 32'(got.win));
            check("lose_after", 32'(bus.lose), 32'(got.lose));
            check("black_hold", 32'(bus.black), 32'(got.b));
        end
    endtask

    initial begin
        int          sv_cnt;
        logic [11:0] g;
        rst            = 1'b1;
        bus.new_game   = 1'b0;
        bus.btn_select = 1'b0;
        bus.btn_mode   = 1'b0;
        bus.secret_in  = '0;
        bus.guess_in   = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_mode", 32'(bus.mode), 0);
        check("rst_store", 32'(bus.store), 0);
        check("rst_turn", 32'(bus.turn), 0);
        check("rst_black", 32'(bus.black), 0);
        check("rst_white", 32'(bus.white), 0);
        check("rst_valid", 32'(bus.score_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_win", 32'(bus.win), 0);
        check("rst_lose", 32'(bus.lose), 0);

        // btn_select / btn_mode in IDLE are ignored
        bus.btn_select = 1'b1;
        bus.btn_mode   = 1'b1;
        tick();
        bus.btn_select = 1'b0;
        bus.btn_mode   = 1'b0;
        check("idle_store", 32'(bus.store), 0);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_mode", 32'(bus.mode), 0);
        tick();
        check("idle_turn", 32'(bus.turn), 0);

        // Game 1: secret {1,2,3,4}, win on turn 3
        start_game(12'o1234);
        play_guess(12'o1243, 1'b0);
        play_guess(12'o1122, 1'b0);
        play_guess(12'o4321, 1'b1);
        check("turn_before_win", 32'(bus.turn), 3);
        play_guess(12'o1234, 1'b0);

        // Terminal WIN: select ignored, mode toggles
        bus.btn_select = 1'b1;
        tick();
        bus.btn_select = 1'b0;
        check("win_no_store", 32'(bus.store), 0);
        check("win_no_busy", 32'(bus.busy), 0);
        bus.btn_mode = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
        check("win_mode_on", 32'(bus.mode), 1);
        bus.btn_mode = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
        check("win_mode_off", 32'(bus.mode), 0);
        check("win_held", 32'(bus.win), 1);
        bus.btn_mode = 1'b1;
        tick();
        bus.btn_mode = 1'b0;

        // Game 2: new_game clears mode/win/black; eight wrong guesses -> LOSE
        start_game(12'o5670);
        check("ng_mode", 32'(bus.mode), 0);
        check("ng_win", 32'(bus.win), 0);
        check("ng_black", 32'(bus.black), 0);
        check("ng_turn", 32'(bus.turn), 0);
        for (int k = 0; k < 8; k++) begin
            g = 12'($urandom_range(0, 4095));
            if (g == secret_m) g = g ^ 12'o0001;
            play_guess(g, 1'b0);
        end
        bus.btn_select = 1'b1;
        tick();
        bus.btn_select = 1'b0;
        check("lose_no_store", 32'(bus.store), 0);
        tick();
        check("lose_turn_held", 32'(bus.turn), 7);
        check("lose_held", 32'(bus.lose), 1);

        // Game 3: abort scoring with new_game at cycle 10
        start_game(12'o7001);
        check("ng_lose_clear", 32'(bus.lose), 0);
        bus.guess_in   = 12'o7001;
        bus.btn_select = 1'b1;
        tick();
        bus.btn_select = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        bus.btn_mode = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
        check("scorew_mode_held", 32'(bus.mode), 0);
        tick();
        bus.new_game  = 1'b1;
        bus.secret_in = 12'o3300;
        tick();
        bus.new_game  = 1'b0;
        secret_m      = 12'o3300;
        turn_m        = '0;
        sv_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            sv_cnt += 32'(bus.score_valid);
            sv_cnt += 32'(bus.store);
            tick();
        end
        check("abort_no_valid", 32'(sv_cnt), 0);
        check("abort_turn", 32'(bus.turn), 0);
        check("abort_busy", 32'(bus.busy), 0);

        // ENTRY with mode=1: select ignored
        bus.btn_mode = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
        check("entry_mode_on", 32'(bus.mode), 1);
        bus.btn_select = 1'b1;
        tick();
        bus.btn_select = 1'b0;
        check("hist_no_store", 32'(bus.store), 0);
        check("hist_no_busy", 32'(bus.busy), 0);
        bus.btn_mode = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
        check("entry_mode_off", 32'(bus.mode), 0);

        // Guess accepted in ENTRY after abort, with simultaneous btn_mode
        play_guess(12'o0033, 1'b1);

        // new_game + btn_select: guess dropped
        bus.new_game   = 1'b1;
        bus.btn_select = 1'b1;
        bus.secret_in  = 12'o1111;
        tick();
        bus.new_game   = 1'b0;
        bus.btn_select = 1'b0;
        secret_m       = 12'o1111;
        turn_m         = '0;
        check("ng_sel_store", 32'(bus.store), 0);
        check("ng_sel_busy", 32'(bus.busy), 0);
        play_guess(12'o1111, 1'b0);

        // rst overrides new_game
        rst          = 1'b1;
        bus.new_game = 1'b1;
        tick();
        rst          = 1'b0;
        bus.new_game = 1'b0;
        check("rst_ovr_win", 32'(bus.win), 0);
        check("rst_ovr_black", 32'(bus.black), 0);
        bus.btn_select = 1'b1;
        tick();
        bus.btn_select = 1'b0;
        check("rst_ovr_idle_store", 32'(bus.store), 0);

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
